// File: rtl/dma_burst_scheduler_pkg.sv
// Shared definitions for the DMA read-burst scheduler: FSM encoding and weight rules.
package dma_sched_pkg;

    // One-hot style encoding leaves 2'b00 and 2'b11 as detectable illegal states.
    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'b01,
        SCHED_ISSUE = 2'b10
    } schedState_t;

    // A programmed weight of zero still grants one burst per turn.
    localparam int unsigned ZERO_WEIGHT_AS = 1;

endpackage

// File: rtl/dma_burst_scheduler_if.sv
// Burst issue and completion signals between the scheduler and the downstream read engine.
interface dma_burst_scheduler_if #(
    parameter int NO_OF_CHANS = 4,
    parameter int LEN_WIDTH   = 8
);
    // A burst transfers on a rising clock edge where issueValid && issueReady; once
    // raised, issueValid/issueChan/issueLen hold until that edge. doneValid is a
    // one-cycle pulse per completed burst and has no ready.
    logic                   issueValid;
    logic                   issueReady;
    logic [NO_OF_CHANS-1:0] issueChan;
    logic [LEN_WIDTH-1:0]   issueLen;
    logic                   doneValid;

    modport master (
        output issueValid, issueChan, issueLen,
        input  issueReady, doneValid
    );

    modport slave (
        input  issueValid, issueChan, issueLen,
        output issueReady, doneValid
    );
endinterface

// File: rtl/dma_sched_rr_pick.sv
// Combinational round-robin picker: lowest request above the pointer, else lowest request overall.
module dma_sched_rr_pick #(
    parameter  int NO_OF_CHANS = 4,
    localparam int PTR_W       = (NO_OF_CHANS > 1) ? $clog2(NO_OF_CHANS) : 1
) (
    input  logic [NO_OF_CHANS-1:0] req,
    input  logic [PTR_W-1:0]       pointer,
    output logic [NO_OF_CHANS-1:0] grant
);

    logic [NO_OF_CHANS-1:0] masked;
    logic [NO_OF_CHANS-1:0] source;
    logic                   found;

    always_comb begin
        masked = '0;
        grant  = '0;
        found  = 1'b0;
        for (int i = 0; i < NO_OF_CHANS; i++) begin
            masked[i] = req[i] && (i > int'(pointer));
        end
        source = (masked != '0) ? masked : req;
        for (int i = 0; i < NO_OF_CHANS; i++) begin
            if (source[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_burst_scheduler.sv
// Weighted round-robin scheduler issuing read bursts from NO_OF_CHANS channels, one at a time.
// Optional per-channel grant counters are built when DMA_SCHED_STATS_EN is defined.
module dma_burst_scheduler
    import dma_sched_pkg::*;
#(
    parameter  int NO_OF_CHANS     = 4,
    parameter  int WEIGHT_WIDTH    = 4,
    parameter  int LEN_WIDTH       = 8,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic [NO_OF_CHANS-1:0]            chanReq,
    input  logic [NO_OF_CHANS*LEN_WIDTH-1:0]  chanLen,
    input  logic [NO_OF_CHANS*WEIGHT_WIDTH-1:0] chanWeight,
    dma_burst_scheduler_if.master             issueBus,
    output logic [OUT_WIDTH-1:0]              outstanding,
    output logic                              errUnderflow,
    output schedState_t                       dbgState
`ifdef DMA_SCHED_STATS_EN
    ,
    output logic [NO_OF_CHANS*16-1:0]         grantCount
`endif
);

    localparam int PTR_W = (NO_OF_CHANS > 1) ? $clog2(NO_OF_CHANS) : 1;
    localparam logic [OUT_WIDTH-1:0]    OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OUT_WIDTH-1:0]    OUT_ONE = OUT_WIDTH'(1);
    localparam logic [WEIGHT_WIDTH-1:0] CNT_ONE = WEIGHT_WIDTH'(1);
    localparam logic [WEIGHT_WIDTH-1:0] MIN_QUOTA = WEIGHT_WIDTH'(ZERO_WEIGHT_AS);

    schedState_t state, stateNext;

    logic [PTR_W-1:0]        holder;
    logic [WEIGHT_WIDTH-1:0] burstCnt;
    logic [WEIGHT_WIDTH-1:0] holderWeight;
    logic [WEIGHT_WIDTH-1:0] holderQuota;
    logic [NO_OF_CHANS-1:0]  holderOneHot;
    logic [NO_OF_CHANS-1:0]  rrGrant;
    logic [NO_OF_CHANS-1:0]  pickGrant;
    logic [PTR_W-1:0]        pickIdx;
    logic [LEN_WIDTH-1:0]    pickLen;

    logic [NO_OF_CHANS-1:0]  issueChanQ;
    logic [LEN_WIDTH-1:0]    issueLenQ;
    logic [PTR_W-1:0]        issueIdxQ;

    logic keepHolder;
    logic canIssue;
    logic loadIssue;
    logic handshake;

    dma_sched_rr_pick #(
        .NO_OF_CHANS(NO_OF_CHANS)
    ) rrPick (
        .req    (chanReq),
        .pointer(holder),
        .grant  (rrGrant)
    );

    // burstCnt == 0 means no holder yet, so the first pick after reset is pure round-robin.
    always_comb begin
        holderWeight = chanWeight[holder*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        holderQuota  = (holderWeight == '0) ? MIN_QUOTA : holderWeight;
        keepHolder   = (burstCnt != '0) && chanReq[holder] && (burstCnt < holderQuota);
        holderOneHot = '0;
        holderOneHot[holder] = 1'b1;
        pickGrant = keepHolder ? holderOneHot : rrGrant;
        pickIdx   = '0;
        for (int i = 0; i < NO_OF_CHANS; i++) begin
            if (pickGrant[i]) pickIdx = PTR_W'(i);
        end
        pickLen = chanLen[pickIdx*LEN_WIDTH +: LEN_WIDTH];
    end

    assign canIssue  = (chanReq != '0) && (outstanding < OUT_MAX);
    assign handshake = (state == SCHED_ISSUE) && issueBus.issueReady;

    always_ff @(posedge clock) begin
        if (!resetn) state <= SCHED_IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadIssue = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (canIssue) begin
                    stateNext = SCHED_ISSUE;
                    loadIssue = 1'b1;
                end
            end
            SCHED_ISSUE: begin
                if (issueBus.issueReady) stateNext = SCHED_IDLE;
            end
            default: stateNext = SCHED_IDLE;
        endcase
    end

    // Issue fields are captured once at the decision and frozen until the handshake.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            issueChanQ <= '0;
            issueLenQ  <= '0;
            issueIdxQ  <= '0;
        end else if (loadIssue) begin
            issueChanQ <= pickGrant;
            issueLenQ  <= pickLen;
            issueIdxQ  <= pickIdx;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            holder   <= PTR_W'(NO_OF_CHANS - 1);
            burstCnt <= '0;
        end else if (handshake) begin
            holder <= issueIdxQ;
            if ((issueIdxQ == holder) && (burstCnt != '0)) begin
                if (burstCnt != '1) burstCnt <= burstCnt + CNT_ONE;
            end else begin
                burstCnt <= CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            outstanding  <= '0;
            errUnderflow <= 1'b0;
        end else if (handshake && !issueBus.doneValid) begin
            outstanding <= outstanding + OUT_ONE;
        end else if (!handshake && issueBus.doneValid) begin
            if (outstanding == '0) errUnderflow <= 1'b1;
            else                   outstanding  <= outstanding - OUT_ONE;
        end
    end

    assign issueBus.issueValid = (state == SCHED_ISSUE);
    assign issueBus.issueChan  = issueChanQ;
    assign issueBus.issueLen   = issueLenQ;
    assign dbgState            = state;

`ifdef DMA_SCHED_STATS_EN
    logic [15:0] grantCnt [NO_OF_CHANS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NO_OF_CHANS; i++) begin
            if (!resetn) begin
                grantCnt[i] <= '0;
            end else if (handshake && issueChanQ[i] && (grantCnt[i] != 16'hFFFF)) begin
                grantCnt[i] <= grantCnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grantCount = '0;
        for (int i = 0; i < NO_OF_CHANS; i++) begin
            grantCount[i*16 +: 16] = grantCnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Scoreboard bench for dma_burst_scheduler: expected bursts queued at stimulus time, checked on handshake.
module tb_dma_burst_scheduler;
    import dma_sched_pkg::*;

    localparam int NCH  = 4;
    localparam int WW   = 4;
    localparam int LW   = 8;
    localparam int MAXO = 2;
    localparam int OW   = $clog2(MAXO + 1);
    localparam int W    = NCH + LW;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic [NCH-1:0]      chanReq = '0;
    logic [NCH*LW-1:0]   chanLen = '0;
    logic [NCH*WW-1:0]   chanWeight = '0;
    logic [OW-1:0]       outstanding;
    logic                errUnderflow;
    schedState_t         dbgState;
`ifdef DMA_SCHED_STATS_EN
    logic [NCH*16-1:0]   grantCount;
`endif

    dma_burst_scheduler_if #(.NO_OF_CHANS(NCH), .LEN_WIDTH(LW)) bus ();

    dma_burst_scheduler #(
        .NO_OF_CHANS(NCH), .WEIGHT_WIDTH(WW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .chanReq     (chanReq),
        .chanLen     (chanLen),
        .chanWeight  (chanWeight),
        .issueBus    (bus.master),
        .outstanding (outstanding),
        .errUnderflow(errUnderflow),
        .dbgState    (dbgState)
`ifdef DMA_SCHED_STATS_EN
        ,
        .grantCount  (grantCount)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    int testsRun = 0;
    int testsFailed = 0;
    int hsCount = 0;
    logic [W-1:0] exp_q[$];
    logic prevHs = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (resetn && prevHs) checkEq("idle_gap", 32'(bus.issueValid), 32'd0);
        prevHs = resetn && bus.issueValid && bus.issueReady;
        if (prevHs) begin
            hsCount++;
            checkEq("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkEq("issue_chan", 32'(bus.issueChan), 32'(e[W-1:LW]));
                checkEq("issue_len", 32'(bus.issueLen), 32'(e[LW-1:0]));
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        chanReq = '0;
        bus.issueReady = 1'b0;
        bus.doneValid = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    task automatic randLens();
        for (int c = 0; c < NCH; c++) chanLen[c*LW +: LW] = 8'($urandom_range(1, 255));
    endtask

    task automatic pushExp(input int ch);
        logic [NCH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        exp_q.push_back({oh, chanLen[ch*LW +: LW]});
    endtask

    task automatic pulseDone();
        bus.doneValid = 1'b1;
        tick(1);
        bus.doneValid = 1'b0;
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (bus.issueValid) ok = 1'b1;
        end
        checkEq("valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic waitHs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (bus.issueValid && bus.issueReady) ok = 1'b1;
        end
        checkEq("hs_seen", 32'(ok), 32'd1);
        tick(1);
    endtask

    // each burst is completed right after its handshake so outstanding never blocks
    task automatic runIssues(input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            waitHs(ok);
            if (k == n - 1) chanReq = '0;
            if (ok) pulseDone();
        end
    endtask

    initial begin
        bit ok;
        int base;
        logic [LW-1:0] expLen;
        bus.issueReady = 1'b0;
        bus.doneValid = 1'b0;

        doReset();
        @(negedge clock);
        checkEq("rst_valid", 32'(bus.issueValid), 32'd0);
        checkEq("rst_chan", 32'(bus.issueChan), 32'd0);
        checkEq("rst_len", 32'(bus.issueLen), 32'd0);
        checkEq("rst_outstanding", 32'(outstanding), 32'd0);
        checkEq("rst_err", 32'(errUnderflow), 32'd0);
        checkEq("rst_state", 32'(dbgState), 32'(SCHED_IDLE));

        // alternating two channels, weight 1
        tick(1);
        randLens();
        chanWeight = {4'd1, 4'd1, 4'd1, 4'd1};
        pushExp(1); pushExp(3); pushExp(1); pushExp(3);
        bus.issueReady = 1'b1;
        chanReq = 4'b1010;
        runIssues(4);
        tick(2);
        checkEq("a_drain", 32'(exp_q.size()), 32'd0);
        checkEq("a_outstanding", 32'(outstanding), 32'd0);

        // weighted: chan0 gets three in a row
        doReset();
        randLens();
        chanWeight = {4'd1, 4'd1, 4'd1, 4'd3};
        pushExp(0); pushExp(0); pushExp(0); pushExp(1);
        pushExp(0); pushExp(0); pushExp(0); pushExp(1);
        bus.issueReady = 1'b1;
        chanReq = 4'b0011;
        runIssues(8);
        tick(2);
        checkEq("b_drain", 32'(exp_q.size()), 32'd0);

        // zero weight behaves as one
        doReset();
        randLens();
        chanWeight = '0;
        pushExp(0); pushExp(1); pushExp(0); pushExp(1);
        bus.issueReady = 1'b1;
        chanReq = 4'b0011;
        runIssues(4);
        tick(2);

        // stall: fields hold while inputs churn
        doReset();
        randLens();
        chanWeight = {4'd1, 4'd1, 4'd1, 4'd1};
        expLen = chanLen[2*LW +: LW];
        pushExp(2);
        chanReq = 4'b0100;
        waitValid(ok);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chanReq = 4'($urandom_range(0, 15));
            randLens();
            @(negedge clock);
            checkEq("stall_valid", 32'(bus.issueValid), 32'd1);
            checkEq("stall_chan", 32'(bus.issueChan), 32'b0100);
            checkEq("stall_len", 32'(bus.issueLen), 32'(expLen));
        end
        tick(1);
        chanReq = '0;
        bus.issueReady = 1'b1;
        runIssues(1);
        tick(2);

        // outstanding limit with no completions
        doReset();
        randLens();
        base = hsCount;
        pushExp(0); pushExp(1);
        bus.issueReady = 1'b1;
        chanReq = 4'b1111;
        tick(20);
        @(negedge clock);
        checkEq("lim_hs_count", 32'(hsCount - base), 32'd2);
        checkEq("lim_outstanding", 32'(outstanding), 32'd2);
        checkEq("lim_valid", 32'(bus.issueValid), 32'd0);
        tick(1);
        pushExp(2);
        pulseDone();
        waitHs(ok);
        chanReq = '0;
        tick(3);
        checkEq("lim_hs_after_done", 32'(hsCount - base), 32'd3);
        checkEq("lim_outstanding2", 32'(outstanding), 32'd2);

        // done coincident with handshake, then underflow
        pulseDone();
        @(negedge clock);
        checkEq("co_pre", 32'(outstanding), 32'd1);
        tick(1);
        pushExp(3);
        chanReq = 4'b1000;
        waitValid(ok);
        bus.doneValid = 1'b1;
        chanReq = '0;
        tick(1);
        bus.doneValid = 1'b0;
        @(negedge clock);
        checkEq("co_outstanding", 32'(outstanding), 32'd1);
        tick(1);
        pulseDone();
        @(negedge clock);
        checkEq("drain_outstanding", 32'(outstanding), 32'd0);
        checkEq("drain_err", 32'(errUnderflow), 32'd0);
        tick(1);
        pulseDone();
        tick(3);
        @(negedge clock);
        checkEq("uf_outstanding", 32'(outstanding), 32'd0);
        checkEq("uf_err", 32'(errUnderflow), 32'd1);

        // reset mid-issue; holder moved to chan1 first
        tick(1);
        randLens();
        pushExp(1);
        chanReq = 4'b0010;
        runIssues(1);
        tick(1);
        bus.issueReady = 1'b0;
        chanReq = 4'b1111;
        waitValid(ok);
        resetn = 1'b0;
        tick(1);
        checkEq("mid_rst_valid", 32'(bus.issueValid), 32'd0);
        checkEq("mid_rst_chan", 32'(bus.issueChan), 32'd0);
        checkEq("mid_rst_len", 32'(bus.issueLen), 32'd0);
        checkEq("mid_rst_outstanding", 32'(outstanding), 32'd0);
        checkEq("mid_rst_err", 32'(errUnderflow), 32'd0);
        resetn = 1'b1;
        bus.issueReady = 1'b1;
        pushExp(0);
        runIssues(1);
        tick(3);

        checkEq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dma_burst_scheduler.md
DMA_BURST_SCHEDULER -- requirements
Module: dma_burst_scheduler

Interface
REQ-001 Parameter NO_OF_CHANS, default 4: number of DMA channels sharing the read-burst issue port.
REQ-002 Parameter WEIGHT_WIDTH, default 4: width of each per-channel weight.
REQ-003 Parameter LEN_WIDTH, default 8: width of burst length.
REQ-004 Parameter MAX_OUTSTANDING, default 8: maximum bursts in flight; OUT_WIDTH = clog2(MAX_OUTSTANDING+1).
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 chanReq  input  NO_OF_CHANS  per-channel burst request, level.
REQ-008 chanLen  input  NO_OF_CHANS*LEN_WIDTH  per-channel burst length, channel i at slice i.
REQ-009 chanWeight  input  NO_OF_CHANS*WEIGHT_WIDTH  consecutive-burst quota per channel; 0 treated as 1.
REQ-010 issueReady  input  1  downstream address channel ready.
REQ-011 doneValid  input  1  one burst completed downstream, single-cycle pulse.
REQ-012 issueValid  output  1  burst issue valid.
REQ-013 issueChan  output  NO_OF_CHANS  one-hot granted channel.
REQ-014 issueLen  output  LEN_WIDTH  length of issued burst.
REQ-015 outstanding  output  OUT_WIDTH  bursts issued and not yet done.
REQ-016 errUnderflow  output  1  sticky: doneValid seen with outstanding == 0.

Function
REQ-017 FSM shall have states IDLE and ISSUE; illegal encodings shall return to IDLE.
REQ-018 IDLE -> ISSUE when any chanReq set and outstanding < MAX_OUTSTANDING; issueValid/issueChan/issueLen registered, asserted the cycle after the decision.
REQ-019 Selection: if current holder still requests and burstCnt < weight, holder shall be kept; otherwise round-robin from channel above holder, wrapping to 0.
REQ-020 After reset, lowest-numbered requesting channel shall win first.
REQ-021 In ISSUE, issueValid, issueChan, issueLen shall hold stable until issueValid && issueReady, regardless of chanReq or chanLen changes.
REQ-022 On handshake: burstCnt increments for same holder, resets to 1 on holder change; FSM returns to IDLE (one idle cycle between issues).
REQ-023 outstanding: +1 on issue handshake, -1 on doneValid, unchanged when both in same cycle.
REQ-024 outstanding == MAX_OUTSTANDING shall block IDLE -> ISSUE; it shall never exceed MAX_OUTSTANDING.
REQ-025 doneValid with outstanding == 0 shall leave outstanding at 0 and set errUnderflow until reset.
REQ-026 Channel dropping chanReq while not granted shall simply be skipped; no request is queued.

Reset
REQ-027 resetn low at a clock edge: state IDLE, issueValid 0, issueChan 0, issueLen 0, outstanding 0, errUnderflow 0, burstCnt 0, holder pointer = channel NO_OF_CHANS-1.
REQ-028 Reset mid-ISSUE shall drop the pending issue with no handshake; in-flight count is discarded.

Configuration
REQ-029 DMA_SCHED_STATS_EN defined: adds output grantCount (NO_OF_CHANS*16), per-channel issue-handshake counters, saturating at 16'hFFFF, reset to 0.
REQ-030 DMA_SCHED_STATS_EN undefined: no grantCount port or counters; all other behaviour identical.

Structure
REQ-031 Package dma_sched_pkg shall hold FSM state encoding and the weight-0-as-1 rule constant.
REQ-032 One sub-module, dma_sched_rr_pick: combinational masked/unmasked round-robin picker (req, pointer -> one-hot).

Verification
REQ-033 Reset, chanReq=4'b1010, weights 1, issueReady=1 -> issues chan1, chan3, chan1, chan3, each issueValid pulse separated by one idle cycle.
REQ-034 chanReq=4'b0011, weight0=3, weight1=1 -> sequence chan0,chan0,chan0,chan1,chan0...
REQ-035 issueReady=0 for 5 cycles, chanReq and chanLen toggled -> issueChan/issueLen constant until ready.
REQ-036 MAX_OUTSTANDING=2, no doneValid -> exactly 2 issues, then issueValid stays 0; one doneValid -> one more issue.
REQ-037 doneValid coincident with issue handshake at outstanding=1 -> outstanding stays 1; doneValid at 0 -> errUnderflow=1, outstanding=0.
REQ-038 resetn low while issueValid=1 -> next cycle all outputs 0, then chan0 wins first with chanReq=4'b1111.
